// File: rtl/step_controller.sv
// Run/single-step debug controller: synchronizes and debounces the raw change/step
// inputs and owns the run/step mode that drives the pipeline clock enable.
module step_controller #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 2,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             change,
  input  logic             step,
  input  logic             brk,
  output logic             cpu_en,
  output logic             run_mode,
  output logic [CNT_W-1:0] step_count
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned N_IN = 2;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STEP_IDLE  = 2'd1,
    STEP_PULSE = 2'd2
  } state_t;

  state_t                 state;
  logic [N_IN-1:0]        raw;
  logic [N_IN-1:0]        sync_lvl;
  logic [N_IN-1:0]        filt;
  logic [N_IN-1:0]        filt_d;
  logic [N_IN-1:0]        rise;
  logic [SYNC_STAGES-1:0] sync_chain [N_IN];
  logic [DB_W-1:0]        db_cnt     [N_IN];
  logic                   rise_change;
  logic                   rise_step;

  // Channel 0 is change, channel 1 is step.
  assign raw = {step, change};

  always_comb begin
    sync_lvl = '0;
    for (int i = 0; i < N_IN; i++) begin
      sync_lvl[i] = sync_chain[i][SYNC_STAGES-1];
    end
  end

  assign rise        = filt & ~filt_d;
  assign rise_change = rise[0];
  assign rise_step   = rise[1];

  // Synchronizer chain and debounce filter; a mismatch must persist DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_IN; i++) begin
        sync_chain[i] <= '0;
        db_cnt[i]     <= '0;
      end
      filt   <= '0;
      filt_d <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        sync_chain[i] <= {sync_chain[i][SYNC_STAGES-2:0], raw[i]};
        if (sync_lvl[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          filt[i]   <= sync_lvl[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
      filt_d <= filt;
    end
  end

  // Mode FSM; outputs are registered alongside the state they decode.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= RUN;
      cpu_en     <= 1'b1;
      run_mode   <= 1'b1;
      step_count <= '0;
    end else begin
      case (state)
        RUN: begin
          if (brk || rise_change) begin
            state    <= STEP_IDLE;
            cpu_en   <= 1'b0;
            run_mode <= 1'b0;
          end
        end
        STEP_IDLE: begin
          if (rise_change) begin
            state    <= RUN;
            cpu_en   <= 1'b1;
            run_mode <= 1'b1;
          end else if (rise_step) begin
            state    <= STEP_PULSE;
            cpu_en   <= 1'b1;
            run_mode <= 1'b0;
          end
        end
        STEP_PULSE: begin
          step_count <= step_count + CNT_W'(1);
          if (rise_change) begin
            state    <= RUN;
            cpu_en   <= 1'b1;
            run_mode <= 1'b1;
          end else begin
            state    <= STEP_IDLE;
            cpu_en   <= 1'b0;
            run_mode <= 1'b0;
          end
        end
        default: begin
          state    <= RUN;
          cpu_en   <= 1'b1;
          run_mode <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_controller.sv
// Self-checking bench for step_controller: directed scenarios plus random traffic,
// compared against a sample-history reference model of the mode behaviour.
module tb_step_controller;

  localparam int unsigned S = 2;
  localparam int unsigned D = 2;

  logic        clock  = 1'b0;
  logic        reset  = 1'b1;
  logic        change = 1'b0;
  logic        step   = 1'b0;
  logic        brk    = 1'b0;
  logic        cpu_en, run_mode, cpu_en2, run_mode2;
  logic [15:0] cnt16;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  step_controller #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .change(change), .step(step), .brk(brk),
    .cpu_en(cpu_en), .run_mode(run_mode), .step_count(cnt16)
  );

  step_controller #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .CNT_W(2)) dut_w (
    .clock(clock), .reset(reset), .change(change), .step(step), .brk(brk),
    .cpu_en(cpu_en2), .run_mode(run_mode2), .step_count(cnt2)
  );

  // Reference model: keeps raw and synced sample histories; a filtered level flips
  // once the last D synced samples all disagree with it.
  bit          raw_h [2][8];
  bit          syn_h [2][8];
  bit          m_filt [2];
  bit          m_filt_d [2];
  bit          m_run   = 1'b1;
  bit          m_pulse = 1'b0;
  int unsigned m_cnt   = 0;

  always @(posedge clock) begin : model
    bit rin [2];
    bit rc, rs, differ;
    rin[0] = change;
    rin[1] = step;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < 8; k++) begin
          raw_h[i][k] = 1'b0;
          syn_h[i][k] = 1'b0;
        end
        m_filt[i]   = 1'b0;
        m_filt_d[i] = 1'b0;
      end
      m_run   = 1'b1;
      m_pulse = 1'b0;
      m_cnt   = 0;
    end else begin
      rc = m_filt[0] & ~m_filt_d[0];
      rs = m_filt[1] & ~m_filt_d[1];
      for (int i = 0; i < 2; i++) begin
        for (int k = 7; k > 0; k--) syn_h[i][k] = syn_h[i][k-1];
        syn_h[i][0] = raw_h[i][S-1];
        differ = 1'b1;
        for (int k = 0; k < D; k++) if (syn_h[i][k] == m_filt[i]) differ = 1'b0;
        m_filt_d[i] = m_filt[i];
        if (differ) m_filt[i] = ~m_filt[i];
        for (int k = 7; k > 0; k--) raw_h[i][k] = raw_h[i][k-1];
        raw_h[i][0] = rin[i];
      end
      if (m_pulse) m_cnt = m_cnt + 1;
      if (m_run) begin
        if (brk || rc) m_run = 1'b0;
      end else if (m_pulse) begin
        m_pulse = 1'b0;
        if (rc) m_run = 1'b1;
      end else begin
        if (rc) m_run = 1'b1;
        else if (rs) m_pulse = 1'b1;
      end
    end
  end

  function automatic logic [21:0] obs();
    return {cpu_en, run_mode, cpu_en2, run_mode2, cnt16, cnt2};
  endfunction

  function automatic logic [21:0] expv();
    logic e;
    logic [31:0] c;
    e = m_run | m_pulse;
    c = m_cnt;
    return {e, logic'(m_run), e, logic'(m_run), c[15:0], c[1:0]};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; change = 1'b0; step = 1'b0; brk = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    checks++;
    if ({cpu_en, run_mode, cnt16} !== {1'b1, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL reset_state: got en=%b run=%b cnt=%0d want en=1 run=1 cnt=0", cpu_en, run_mode, cnt16);
    end
    for (int i = 1; i <= 20; i++) begin
      cyc();
      checks++;
      if ({cpu_en, run_mode} !== 2'b11) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: got en=%b run=%b want 1 1", i, cpu_en, run_mode);
      end
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL model_reset cyc %0d: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_mode_toggle();
    bit want;
    change = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      want = (i < 5);
      checks++;
      if (run_mode !== want || cpu_en !== want) begin
        errors++;
        $display("FAIL toggle_off cyc %0d: got run=%b en=%b want %b", i, run_mode, cpu_en, want);
      end
    end
    change = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL model_toggle cyc %0d: got %h want %h", i, obs(), expv());
      end
    end
    change = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      want = (i >= 5);
      checks++;
      if (run_mode !== want || cpu_en !== want) begin
        errors++;
        $display("FAIL toggle_on cyc %0d: got run=%b en=%b want %b", i, run_mode, cpu_en, want);
      end
    end
  endtask

  task automatic press_step(input string tag, output int pulses);
    pulses = 0;
    step = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (i == 5) step = 1'b0;
      cyc();
      if (cpu_en === 1'b1) pulses++;
      checks++;
      if (cpu_en !== (i == 5)) begin
        errors++;
        $display("FAIL %s_pulse cyc %0d: got en=%b want %b", tag, i, cpu_en, (i == 5));
      end
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL model_%s cyc %0d: got %h want %h", tag, i, obs(), expv());
      end
    end
  endtask

  task automatic test_single_step();
    int p, total;
    change = 1'b0;
    repeat (4) cyc();
    change = 1'b1;
    repeat (6) cyc();
    change = 1'b0;
    repeat (4) cyc();
    checks++;
    if (run_mode !== 1'b0 || cpu_en !== 1'b0) begin
      errors++;
      $display("FAIL step_mode_entry: got run=%b en=%b want 0 0", run_mode, cpu_en);
    end
    total = 0;
    for (int k = 0; k < 3; k++) begin
      press_step("single", p);
      total += p;
    end
    checks++;
    if (total != 3 || cnt16 !== 16'd3) begin
      errors++;
      $display("FAIL single_step_count: got pulses=%0d cnt=%0d want 3 3", total, cnt16);
    end
  endtask

  task automatic test_glitch();
    #2 change = 1'b1;
    #1 change = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      checks++;
      if (run_mode !== 1'b0 || cpu_en !== 1'b0) begin
        errors++;
        $display("FAIL glitch_short cyc %0d: got run=%b en=%b want 0 0", i, run_mode, cpu_en);
      end
    end
    change = 1'b1;
    cyc();
    change = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      checks++;
      if (run_mode !== 1'b0 || cpu_en !== 1'b0) begin
        errors++;
        $display("FAIL glitch_period cyc %0d: got run=%b en=%b want 0 0", i, run_mode, cpu_en);
      end
    end
  endtask

  task automatic test_simultaneous();
    bit want;
    change = 1'b1;
    step   = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      want = (i >= 5);
      checks++;
      if (run_mode !== want || cnt16 !== 16'd3) begin
        errors++;
        $display("FAIL simul_change_step cyc %0d: got run=%b cnt=%0d want run=%b cnt=3", i, run_mode, cnt16, want);
      end
    end
    change = 1'b0;
    step   = 1'b0;
    repeat (6) cyc();
    change = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      brk = (i == 5);
      cyc();
      want = (i < 5);
      checks++;
      if (run_mode !== want || cpu_en !== want) begin
        errors++;
        $display("FAIL simul_brk_change cyc %0d: got run=%b en=%b want %b", i, run_mode, cpu_en, want);
      end
    end
    brk = 1'b0;
    change = 1'b0;
    repeat (4) cyc();
    brk = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      checks++;
      if (run_mode !== 1'b0 || cpu_en !== 1'b0) begin
        errors++;
        $display("FAIL brk_in_step cyc %0d: got run=%b en=%b want 0 0", i, run_mode, cpu_en);
      end
    end
    brk = 1'b0;
  endtask

  task automatic test_wrap();
    logic [1:0] seq [5];
    int p;
    seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    brk = 1'b1;
    cyc();
    brk = 1'b0;
    cyc();
    for (int k = 0; k < 5; k++) begin
      press_step("wrap", p);
      checks++;
      if (cnt2 !== seq[k]) begin
        errors++;
        $display("FAIL wrap_count step %0d: got %0d want %0d", k + 1, cnt2, seq[k]);
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    step = 1'b1;
    repeat (4) cyc();
    step = 1'b0;
    cyc();
    checks++;
    if (cpu_en !== 1'b1 || run_mode !== 1'b0) begin
      errors++;
      $display("FAIL mid_pulse_setup: got en=%b run=%b want 1 0", cpu_en, run_mode);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
    if ({run_mode, cpu_en, cnt16, cnt2} !== {1'b1, 1'b1, 16'd0, 2'd0}) begin
      errors++;
      $display("FAIL mid_pulse_reset: got run=%b en=%b cnt=%0d cnt2=%0d want 1 1 0 0", run_mode, cpu_en, cnt16, cnt2);
    end
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 600; seg++) begin
      change = 1'($urandom_range(0, 1));
      step   = 1'($urandom_range(0, 1));
      brk    = ($urandom_range(0, 15) == 0);
      reset  = ($urandom_range(0, 199) == 0);
      hold   = $urandom_range(1, 6);
      for (int i = 0; i < hold; i++) begin
        cyc();
        brk   = 1'b0;
        reset = 1'b0;
        checks++;
        if (obs() !== expv()) begin
          errors++;
          $display("FAIL model_random seg %0d: got %h want %h", seg, obs(), expv());
        end
      end
    end
    change = 1'b0;
    step   = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mode_toggle();
    test_single_step();
    test_glitch();
    test_simultaneous();
    test_wrap();
    test_reset_mid_pulse();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_controller.md
# step_controller

Run/single-step controller inside `mips`. It synchronizes and debounces the raw `change` and `step` debug inputs and owns the run/step mode state. It produces `cpu_en`, the clock enable gating every pipeline and PC register. In step mode the CPU advances exactly one cycle per accepted `step` press.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops per raw input; must be ≥ 2.
- `DEBOUNCE_CYCLES`, 2: consecutive stable synced cycles required before the filtered level changes; must be ≥ 1.
- `CNT_W`, 16: width of `step_count`.

- `clock` input, 1: single clock; all state changes on the rising edge.
- `reset` input, 1: synchronous, active-high.
- `change` input, 1: raw, asynchronous level; each accepted rising edge toggles the mode.
- `step` input, 1: raw, asynchronous level; each accepted rising edge requests one CPU cycle in step mode.
- `brk` input, 1: synchronous, from the CPU; high in run mode forces step mode.
- `cpu_en` output, 1: pipeline clock enable.
- `run_mode` output, 1: 1 when in RUN.
- `step_count` output, CNT_W: number of single-step cycles issued; wraps.

## Operation
- Synchronizer per input:
  - `SYNC_STAGES` flop chain, all flops reset to 0.
  - The last stage is `sync_x`.
- Debouncer per input:
  - Holds `filt_x` (reset 0) and a counter (reset 0, width ⌈log2(DEBOUNCE_CYCLES+1)⌉).
  - When `sync_x == filt_x`, the counter clears to 0.
  - When they differ, the counter increments.
  - When the counter would reach `DEBOUNCE_CYCLES`, `filt_x` takes `sync_x` and the counter clears.
  - Any mismatch shorter than `DEBOUNCE_CYCLES` cycles is discarded.
- Edge detect:
  - `rise_x = filt_x & ~filt_x_d`, where `filt_x_d` is a registered copy of `filt_x` (reset 0).
  - `rise_x` is exactly one cycle wide.
- FSM states: RUN, STEP_IDLE, STEP_PULSE. Reset state is RUN.
  - RUN: if `brk`, go to STEP_IDLE. Else if `rise_change`, go to STEP_IDLE. Else stay.
  - STEP_IDLE: if `rise_change`, go to RUN; a simultaneous `rise_step` is dropped. Else if `rise_step`, go to STEP_PULSE. Else stay.
  - STEP_PULSE: if `rise_change`, go to RUN. Else go to STEP_IDLE. `rise_step` here is ignored and not queued.
  - `brk` has no effect outside RUN.
- Outputs (Moore, decoded from the state register):
  - `cpu_en` = (state == RUN) | (state == STEP_PULSE).
  - `run_mode` = (state == RUN).
- `step_count` increments by 1 on every cycle spent in STEP_PULSE.
  - Modulo 2^CNT_W: all-ones wraps to 0.
  - Cleared only by `reset`.

## Timing
- Reset: on the edge where `reset` = 1, state becomes RUN and `step_count` becomes 0.
  - All sync, filter and edge flops and debounce counters become 0.
  - Outputs from the following cycle: `cpu_en` = 1, `run_mode` = 1, `step_count` = 0.
  - Reset applied mid-STEP_PULSE aborts the pulse; `step_count` still clears.
- Input held high across reset: `filt_x` restarts at 0, so the held level produces one accepted rising edge after the normal latency.
- Latency: raw input sampled stable high at edge N.
  - `sync_x` = 1 after edge N+SYNC_STAGES−1.
  - `filt_x` = 1 after edge N+SYNC_STAGES+DEBOUNCE_CYCLES−1.
  - State update, and therefore the `cpu_en` / `run_mode` change, visible after edge N+SYNC_STAGES+DEBOUNCE_CYCLES.
  - Defaults (2, 2): response 4 edges after the first sampling edge.
- `brk` latency: sampled at edge M while in RUN; `cpu_en` = 0 from edge M+1 onward. The instruction in flight at edge M completes.
- Step pulse: `cpu_en` is high for exactly one cycle per accepted step.
- Step repeat rate: back-to-back steps need the filtered level to fall and rise again. The minimum is 2·DEBOUNCE_CYCLES cycles between accepted edges.
- Glitches: a raw pulse narrower than one clock period may or may not be sampled. If sampled for fewer than `DEBOUNCE_CYCLES` consecutive cycles, it is rejected.
- No combinational path from any input to any output.

## Test plan
- Reset:
  - Stimulus: `reset` = 1 for 2 cycles with `change` = `step` = 0, then release.
  - Required: `cpu_en` = 1, `run_mode` = 1, `step_count` = 0 from the first post-reset cycle; no mode change for 20 cycles.
- Mode toggle:
  - Stimulus: `change` rises and holds for 10 cycles.
  - Required: exactly 4 edges after the first sampling edge, `run_mode` and `cpu_en` go 0. Releasing and reasserting `change` (each for ≥ 3 cycles) returns to RUN after the same latency.
- Single step:
  - Stimulus: in STEP_IDLE, three `step` presses, each high for 4 cycles and low for 4 cycles.
  - Required: three isolated 1-cycle `cpu_en` pulses, each 4 edges after its press; `step_count` reads 3.
- Glitch rejection:
  - Stimulus: in STEP_IDLE, a `change` pulse of 1 ns, then a `change` pulse of exactly 1 clock period.
  - Required: the mode stays STEP_IDLE and `cpu_en` stays 0 throughout.
- Simultaneous events:
  - Stimulus: in STEP_IDLE, align `change` and `step` so that `rise_change` and `rise_step` fall in the same cycle.
  - Required: go to RUN, no STEP_PULSE, `step_count` unchanged.
  - Stimulus: in RUN, assert `brk` in the same cycle as `rise_change`.
  - Required: STEP_IDLE.
- Wrap and reset mid-pulse:
  - Stimulus: CNT_W = 2; issue 5 steps.
  - Required: `step_count` sequence 1, 2, 3, 0, 1.
  - Stimulus: assert `reset` during the STEP_PULSE cycle.
  - Required: next cycle `run_mode` = 1, `step_count` = 0.
